// File: rtl/op_pkg.sv
// Shared opcode encodings, instruction-word layout helpers and sequencer states.
package op_pkg;

  // Fractional bits of the fixed-point value word; carried for documentation, no arithmetic here.
  localparam int unsigned Q = 16;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD1 = 3'b001;
  localparam logic [2:0] OP_LOAD2 = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_NEG   = 3'b101;
  localparam logic [2:0] OP_ABS   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HOLD, DONE} state_t;

  // Stack index width: one spare bit so out-of-range indices are representable and detectable.
  function automatic int unsigned idx_w(input int unsigned stack);
    return $clog2(stack) + 1;
  endfunction

  function automatic int unsigned sel_w(input int unsigned nin);
    return (nin > 1) ? $clog2(nin) : 1;
  endfunction

  // Instruction word {op[2:0], i1, i2, i3, src, sel}, sel at the LSBs.
  function automatic int unsigned iword_w(input int unsigned stack, input int unsigned nin);
    return 3 + 3 * idx_w(stack) + 1 + sel_w(nin);
  endfunction

  function automatic int unsigned src_bit(input int unsigned nin);
    return sel_w(nin);
  endfunction

  function automatic int unsigned i3_lsb(input int unsigned nin);
    return sel_w(nin) + 1;
  endfunction

  function automatic int unsigned i2_lsb(input int unsigned stack, input int unsigned nin);
    return i3_lsb(nin) + idx_w(stack);
  endfunction

  function automatic int unsigned i1_lsb(input int unsigned stack, input int unsigned nin);
    return i2_lsb(stack, nin) + idx_w(stack);
  endfunction

  function automatic int unsigned op_lsb(input int unsigned stack, input int unsigned nin);
    return i1_lsb(stack, nin) + idx_w(stack);
  endfunction

endpackage

// File: rtl/op_prog_mem.sv
// Program register file with registered read plus constant table with combinational read.
module op_prog_mem #(
  parameter int unsigned N          = 32,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned NCONST     = 4,
  parameter int unsigned PW         = 4,
  parameter int unsigned SW         = 2,
  parameter int unsigned IWORD      = 18
) (
  input  logic             clk,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IWORD-1:0] prog_data,
  input  logic             const_we,
  input  logic [SW-1:0]    const_addr,
  input  logic [N-1:0]     const_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [IWORD-1:0] rd_data,
  input  logic [SW-1:0]    const_sel,
  output logic [N-1:0]     const_val_c
);

  logic [IWORD-1:0] prog_q  [PROG_DEPTH];
  logic [N-1:0]     const_q [NCONST];

  // Program write port.
  always_ff @(posedge clk) begin
    if (prog_we) prog_q[prog_addr] <= prog_data;
  end

  // Constant write port.
  always_ff @(posedge clk) begin
    if (const_we) const_q[const_addr] <= const_data;
  end

  // Registered read; a same-cycle write to the read slot is forwarded so a run started
  // together with a write sees the new word.
  always_ff @(posedge clk) begin
    rd_data <= (prog_we && (prog_addr == rd_addr)) ? prog_data : prog_q[rd_addr];
  end

  assign const_val_c = (32'(const_sel) < NCONST) ? const_q[const_sel] : '0;

endmodule

// File: rtl/op_sequencer.sv
// Microprogram sequencer issuing opcode/index/value words to operation_machine.
module op_sequencer
  import op_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned STACK      = 5,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned NIN        = 4,
  parameter int unsigned NCONST     = 4,
  parameter int unsigned OP_LAT     = 2,
  localparam int unsigned IW        = idx_w(STACK),
  localparam int unsigned PW        = $clog2(PROG_DEPTH),
  localparam int unsigned SW        = sel_w(NIN),
  localparam int unsigned IWORD     = iword_w(STACK, NIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IWORD-1:0] prog_data,
  input  logic             const_we,
  input  logic [SW-1:0]    const_addr,
  input  logic [N-1:0]     const_data,
  input  logic [NIN*N-1:0] x_in,
  input  logic             start,
  output logic [2:0]       operand,
  output logic [IW-1:0]    index1,
  output logic [IW-1:0]    index2,
  output logic [IW-1:0]    index3,
  output logic [N-1:0]     value,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned SRC_BIT = src_bit(NIN);
  localparam int unsigned I3_LSB  = i3_lsb(NIN);
  localparam int unsigned I2_LSB  = i2_lsb(STACK, NIN);
  localparam int unsigned I1_LSB  = i1_lsb(STACK, NIN);
  localparam int unsigned OP_LSB  = op_lsb(STACK, NIN);
  localparam int unsigned HW      = (OP_LAT > 2) ? $clog2(OP_LAT - 1) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [2:0]       operand_d;
  logic [IW-1:0]    index1_d, index2_d, index3_d;
  logic [N-1:0]     value_d;
  logic             busy_d, done_d, err_d;

  logic             idle_c, fin_c;
  logic [IWORD-1:0] rd_data;
  logic [N-1:0]     const_val_c, x_val_c, load_val_c;
  logic [2:0]       dec_op;
  logic [IW-1:0]    dec_i1, dec_i2, dec_i3;
  logic             dec_src;
  logic [SW-1:0]    dec_sel;
  logic             dec_fault_c, dec_arith_c, dec_load_c;

  assign idle_c = (state_q == IDLE);

  // Writes are only honoured while idle; the read address follows the next pc.
  op_prog_mem #(
    .N(N), .PROG_DEPTH(PROG_DEPTH), .NCONST(NCONST), .PW(PW), .SW(SW), .IWORD(IWORD)
  ) u_mem (
    .clk        (clk),
    .prog_we    (prog_we & idle_c),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .const_we   (const_we & idle_c),
    .const_addr (const_addr),
    .const_data (const_data),
    .rd_addr    (pc_d),
    .rd_data    (rd_data),
    .const_sel  (dec_sel),
    .const_val_c(const_val_c)
  );

  assign dec_op  = rd_data[OP_LSB +: 3];
  assign dec_i1  = rd_data[I1_LSB +: IW];
  assign dec_i2  = rd_data[I2_LSB +: IW];
  assign dec_i3  = rd_data[I3_LSB +: IW];
  assign dec_src = rd_data[SRC_BIT];
  assign dec_sel = rd_data[SW-1:0];

  // Instruction classification and fault detection for the word at pc.
  always_comb begin
    dec_arith_c = (dec_op == OP_ADD) || (dec_op == OP_MUL) ||
                  (dec_op == OP_NEG) || (dec_op == OP_ABS);
    dec_load_c  = (dec_op == OP_LOAD1) || (dec_op == OP_LOAD2);
    dec_fault_c = (32'(dec_i1) >= STACK) || (32'(dec_i2) >= STACK) ||
                  (32'(dec_i3) >= STACK) || (dec_src && (32'(dec_sel) >= NCONST));
  end

  // Load-value source: external operand or constant table.
  always_comb begin
    x_val_c = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (32'(dec_sel) == k) x_val_c = x_in[k*N +: N];
    end
    load_val_c = dec_src ? const_val_c : x_val_c;
  end

  // Next state, next pc and next registered outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hcnt_d    = hcnt_q;
    operand_d = OP_NOP;
    index1_d  = '0;
    index2_d  = '0;
    index3_d  = '0;
    value_d   = '0;
    err_d     = err;
    fin_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        state_d = ISSUE;
        if (dec_op != OP_HALT) begin
          if (dec_fault_c) begin
            err_d = 1'b1;
          end else begin
            operand_d = dec_op;
            index1_d  = dec_i1;
            index2_d  = dec_i2;
            index3_d  = dec_i3;
            if (dec_load_c) value_d = load_val_c;
          end
        end
      end
      ISSUE: begin
        if (dec_op == OP_HALT) begin
          state_d = DONE;
          pc_d    = '0;
        end else if (dec_arith_c && !dec_fault_c && (OP_LAT > 1)) begin
          state_d   = HOLD;
          hcnt_d    = HW'(OP_LAT - 2);
          operand_d = operand;
          index1_d  = index1;
          index2_d  = index2;
          index3_d  = index3;
          value_d   = value;
        end else begin
          fin_c = 1'b1;
        end
      end
      HOLD: begin
        if (hcnt_q == '0) begin
          fin_c = 1'b1;
        end else begin
          hcnt_d    = hcnt_q - HW'(1);
          operand_d = operand;
          index1_d  = index1;
          index2_d  = index2;
          index3_d  = index3;
          value_d   = value;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase

    if (fin_c) begin
      if (pc_q == PW'(PROG_DEPTH - 1)) begin
        state_d = DONE;
        pc_d    = '0;
      end else begin
        state_d = FETCH;
        pc_d    = pc_q + PW'(1);
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, pc and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hcnt_q  <= '0;
      operand <= OP_NOP;
      index1  <= '0;
      index2  <= '0;
      index3  <= '0;
      value   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hcnt_q  <= hcnt_d;
      operand <= operand_d;
      index1  <= index1_d;
      index2  <= index2_d;
      index3  <= index3_d;
      value   <= value_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule
